arp_parser: RTL
===============

# arp_parser

Receive-side ARP frame parser. Consumes the byte stream from the Ethernet MAC RX path, reassembles each frame into an `ether_arp_frame_t`, and filters for ARP requests addressed to the local IP. Accepted requests are held in a single-entry output register and handed to `arp_sender` through a valid/ack handshake. The block also maintains per-outcome statistics counters.

## Interface

**Parameters**
- `P_ACCEPT_BCAST`, default 1: when 1, also accept dst MAC FF:FF:FF:FF:FF:FF in addition to `hw_addr_i`.
- `P_CNT_W`, default 16: width of the statistics counters.

**Ports**
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `hw_addr_i` input 48: local MAC address.
- `ip_addr_i` input 32: local IPv4 address.
- `mac_data_i` input 8: RX byte, MSB-first field order.
- `mac_valid_i` input 1: byte strobe. A frame is one contiguous run of valid-high cycles.
- `arp_req_pkt_o` output `$bits(ether_arp_frame_t)`: accepted request frame.
- `arp_req_pkt_valid_o` output 1: output register holds a frame.
- `arp_req_pkt_ack_i` input 1: consumer takes the frame in this cycle.
- `ok_cnt_o` output `P_CNT_W`: frames accepted.
- `filt_cnt_o` output `P_CNT_W`: frames rejected by filter or runt.
- `ovf_cnt_o` output `P_CNT_W`: accepted frames dropped because the output register was full.

## Operation

**States:** `ST_SYNC`, `ST_IDLE`, `ST_RX`, `ST_CHECK`. The reset state is `ST_SYNC`.

- **ST_SYNC:** ignore all bytes. Go to `ST_IDLE` on the first cycle with `mac_valid_i` = 0. This prevents parsing a frame that was already in progress when reset released.
- **ST_IDLE:**
  - If `mac_valid_i` = 1: capture the byte as byte 0, set `byte_cnt` = 1, go to `ST_RX`.
- **ST_RX:**
  - If `mac_valid_i` = 1: if `byte_cnt` < `lp_ARP_FRM_SZ` (42), shift the byte into the 336-bit shift register. Otherwise discard it (Ethernet padding/FCS).
  - `byte_cnt` increments and saturates at 255.
  - If `mac_valid_i` = 0: go to `ST_CHECK`.
- **ST_CHECK:** evaluate the filter on the shift-register contents as they stand at the start of the cycle. All of the following must hold:
  - `byte_cnt` ≥ 42.
  - `dst_mac` == `hw_addr_i`, or (`P_ACCEPT_BCAST` and `dst_mac` is all ones).
  - `ethertype` == 0x0806, `hw_type` == 0x0001, `proto_type` == 0x0800.
  - `hw_len` == 6, `proto_len` == 4, `opcode` == 0x0001.
  - `target_ip` == `ip_addr_i`.

**Filter outcome (ST_CHECK):**
- Pass, and (`arp_req_pkt_valid_o` = 0 or `arp_req_pkt_ack_i` = 1): load `arp_req_pkt_o`, set valid, increment `ok_cnt_o`.
- Pass, but `arp_req_pkt_valid_o` = 1 and `arp_req_pkt_ack_i` = 0: drop the new frame (held frame is kept), increment `ovf_cnt_o`.
- Fail: increment `filt_cnt_o`.

**Next state after ST_CHECK:**
- If `mac_valid_i` = 1 in the `ST_CHECK` cycle, capture it as byte 0 of the next frame and go to `ST_RX` with `byte_cnt` = 1.
- Otherwise go to `ST_IDLE`.

**Field map (byte index):**
- `dst_mac` 0–5, `src_mac` 6–11, `ethertype` 12–13, `hw_type` 14–15, `proto_type` 16–17.
- `hw_len` 18, `proto_len` 19, `opcode` 20–21.
- `sender_mac` 22–27, `sender_ip` 28–31, `target_mac` 32–37, `target_ip` 38–41.

**Output handshake:**
- `arp_req_pkt_valid_o` clears on the clock edge following a cycle with `ack_i` = 1, unless a new frame loads in that same cycle.
- `arp_req_pkt_o` is stable while valid is high.
- `ack_i` while valid is low is ignored.

**Counters:** increment by 1 and wrap modulo 2^`P_CNT_W`. At most one counter increments per frame.

## Timing

- **Reset values:** `arp_req_pkt_o` = 0, `arp_req_pkt_valid_o` = 0, all counters = 0. Internal `byte_cnt` = 0, shift register = 0, state = `ST_SYNC`.
- **Reset mid-frame:** partial frame is lost with no counter change. The block resumes only after `mac_valid_i` is seen low.
- **Latency:** let cycle E be the first cycle with `mac_valid_i` = 0 after a frame.
  - E: state `ST_RX`, transitions to `ST_CHECK`.
  - E+1: `ST_CHECK`.
  - E+2: `arp_req_pkt_valid_o` = 1 and counters updated.
- **Throughput:** a minimum inter-frame gap of 1 idle cycle is supported with no byte loss.
- **Simultaneous ack and load in ST_CHECK:** the new frame replaces the old one, valid stays 1, no overflow.
- **Configuration inputs:** `hw_addr_i` and `ip_addr_i` are sampled combinationally in `ST_CHECK` and must be stable during it.

## Test plan

- **Valid request:** broadcast dst, ethertype 0x0806, opcode 1, target_ip = `ip_addr_i` = 192.168.1.10, 42 bytes plus 18 pad bytes, then 1 idle cycle.
  - Valid rises at E+2.
  - `arp_req_pkt_o.sender_mac` and `.sender_ip` match the stimulus.
  - `ok_cnt_o` = 1.
  - Ack for 1 cycle → valid low on the next edge.
- **Filter rejects:** separate frames with opcode 2, target_ip 192.168.1.11, ethertype 0x0800, unicast dst ≠ `hw_addr_i`, and a 41-byte runt.
  - Valid stays 0 throughout; `filt_cnt_o` = 5.
- **Overflow:** two valid requests back-to-back with 1-cycle gap, ack held low.
  - First frame is retained; `ovf_cnt_o` = 1, `ok_cnt_o` = 1.
  - Repeat with ack pulsed in the second frame's `ST_CHECK` cycle → second frame is loaded, `ovf_cnt_o` unchanged.
- **Reset mid-frame:** assert `rst` at byte 20, release while `mac_valid_i` is still high for bytes 21–59.
  - No output and counters = 0.
  - The following valid frame is accepted.
- **Back-to-back capture:** next frame's byte 0 arrives exactly in the `ST_CHECK` cycle.
  - Both frames are accepted (ack each); the second frame's fields are correct.
- **Counter wrap:** preload via `P_CNT_W` = 4, send 16 valid frames with ack.
  - `ok_cnt_o` wraps to 0.

Source files
------------

// File: rtl/arp_parser.sv
// Receive-side ARP request parser: reassembles a MAC byte stream and filters for requests to the local IP.
// Result is valid 2 cycles after the frame ends; holds one frame and drops (counts) new accepts while it is unacked.
module arp_parser #(
  parameter int P_ACCEPT_BCAST = 1,
  parameter int P_CNT_W        = 16,
  localparam int LP_FRM_W      = 336
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [47:0]        hw_addr_i,
  input  logic [31:0]        ip_addr_i,
  input  logic [7:0]         mac_data_i,
  input  logic               mac_valid_i,
  output logic [LP_FRM_W-1:0] arp_req_pkt_o,
  output logic               arp_req_pkt_valid_o,
  input  logic               arp_req_pkt_ack_i,
  output logic [P_CNT_W-1:0] ok_cnt_o,
  output logic [P_CNT_W-1:0] filt_cnt_o,
  output logic [P_CNT_W-1:0] ovf_cnt_o
);

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [15:0] hw_type;
    logic [15:0] proto_type;
    logic [7:0]  hw_len;
    logic [7:0]  proto_len;
    logic [15:0] opcode;
    logic [47:0] sender_mac;
    logic [31:0] sender_ip;
    logic [47:0] target_mac;
    logic [31:0] target_ip;
  } ether_arp_frame_t;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RX    = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam logic [7:0]         LP_ARP_FRM_SZ = 8'd42;
  localparam logic [7:0]         LP_CNT_SAT    = 8'd255;
  localparam logic [P_CNT_W-1:0] LP_CNT_ONE    = {{(P_CNT_W-1){1'b0}}, 1'b1};

  state_t                state;
  logic [7:0]            byte_cnt;
  logic [LP_FRM_W-1:0]   shift_q;
  ether_arp_frame_t      frm;
  logic                  dst_ok;
  logic                  filt_pass;
  logic                  out_free;

  // Byte 0 lands in the top bits after 42 shifts, so the shift register maps directly onto the struct.
  assign frm = ether_arp_frame_t'(shift_q);

  assign dst_ok = (frm.dst_mac == hw_addr_i) ||
                  ((P_ACCEPT_BCAST != 0) && (frm.dst_mac == 48'hFFFF_FFFF_FFFF));

  assign filt_pass = (byte_cnt >= LP_ARP_FRM_SZ) && dst_ok &&
                     (frm.ethertype  == 16'h0806) &&
                     (frm.hw_type    == 16'h0001) &&
                     (frm.proto_type == 16'h0800) &&
                     (frm.hw_len     == 8'd6) &&
                     (frm.proto_len  == 8'd4) &&
                     (frm.opcode     == 16'h0001) &&
                     (frm.target_ip  == ip_addr_i);

  assign out_free = !arp_req_pkt_valid_o || arp_req_pkt_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= ST_SYNC;
      byte_cnt            <= 8'd0;
      shift_q             <= '0;
      arp_req_pkt_o       <= '0;
      arp_req_pkt_valid_o <= 1'b0;
      ok_cnt_o            <= '0;
      filt_cnt_o          <= '0;
      ovf_cnt_o           <= '0;
    end else begin
      if (arp_req_pkt_valid_o && arp_req_pkt_ack_i) begin
        arp_req_pkt_valid_o <= 1'b0;
      end

      case (state)
        ST_SYNC: begin
          if (!mac_valid_i) begin
            state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (mac_valid_i) begin
            shift_q  <= {shift_q[LP_FRM_W-9:0], mac_data_i};
            byte_cnt <= 8'd1;
            state    <= ST_RX;
          end
        end

        ST_RX: begin
          if (mac_valid_i) begin
            // Bytes past the ARP payload are padding/FCS and must not disturb the captured fields.
            if (byte_cnt < LP_ARP_FRM_SZ) begin
              shift_q <= {shift_q[LP_FRM_W-9:0], mac_data_i};
            end
            if (byte_cnt != LP_CNT_SAT) begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end else begin
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (filt_pass) begin
            if (out_free) begin
              arp_req_pkt_o       <= shift_q;
              arp_req_pkt_valid_o <= 1'b1;
              ok_cnt_o            <= ok_cnt_o + LP_CNT_ONE;
            end else begin
              ovf_cnt_o <= ovf_cnt_o + LP_CNT_ONE;
            end
          end else begin
            filt_cnt_o <= filt_cnt_o + LP_CNT_ONE;
          end

          // Filter above reads shift_q before this capture overwrites its low byte.
          if (mac_valid_i) begin
            shift_q  <= {shift_q[LP_FRM_W-9:0], mac_data_i};
            byte_cnt <= 8'd1;
            state    <= ST_RX;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule
